// File: rtl/bus_slave_mem_if.sv
// Bus bundle for bus_slave_mem: command inputs, read return, error pulse and counters.
// Uses the same signal names as the slave's documented bus ports.
interface bus_slave_mem_if;
  logic [1:0]  op;
  logic [15:0] adr;
  logic [31:0] data;
  logic [31:0] data_read;
  logic        rd_valid;
  logic        err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  modport master (
    output op, adr, data,
    input  data_read, rd_valid, err, rd_count, wr_count
  );

  modport slave (
    input  op, adr, data,
    output data_read, rd_valid, err, rd_count, wr_count
  );
endinterface

// File: rtl/bus_slave_mem.sv
// Address-decoded 32-bit memory slave with a fixed-latency, fully pipelined read path.
// Misses and reserved ops are rejected with a one-cycle err pulse.
module bus_slave_mem #(
  parameter int          ADDR_BITS  = 4,
  parameter logic [15:0] BASE_ADR   = 16'h0000,
  parameter int          RD_LATENCY = 2
) (
  input logic            clock,
  input logic            reset_n,
  bus_slave_mem_if.slave bus
);

  localparam int          DEPTH    = 1 << ADDR_BITS;
  localparam logic [16:0] LIMIT    = {1'b0, BASE_ADR} + 17'(DEPTH);
  localparam logic [1:0]  OP_READ  = 2'b01;
  localparam logic [1:0]  OP_WRITE = 2'b10;
  localparam logic [1:0]  OP_RSVD  = 2'b11;

  logic [31:0]          mem_q [DEPTH];
  logic                 hit;
  logic [ADDR_BITS-1:0] idx;
  logic                 rd_cmd;
  logic                 wr_cmd;

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] hit_q, hit_d;
  logic [31:0]           dat_q [RD_LATENCY];
  logic [31:0]           dat_d [RD_LATENCY];
  logic                  err_wr_q, err_wr_d;
  logic [15:0]           rd_count_q, rd_count_d;
  logic [15:0]           wr_count_q, wr_count_d;
  logic                  rd_valid;

  // 17-bit compare so a window ending at 16'hFFFF never wraps back to zero.
  assign hit    = (bus.adr >= BASE_ADR) && ({1'b0, bus.adr} < LIMIT);
  assign idx    = ADDR_BITS'(bus.adr - BASE_ADR);
  assign rd_cmd = (bus.op == OP_READ);
  assign wr_cmd = (bus.op == OP_WRITE);

  always_comb begin
    vld_d[0] = rd_cmd;
    hit_d[0] = hit;
    // Memory is read at the sample edge, so a write sampled one edge earlier is already visible.
    dat_d[0] = (rd_cmd && hit) ? mem_q[idx] : 32'h0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      hit_d[i] = hit_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    err_wr_d   = (wr_cmd && !hit) || (bus.op == OP_RSVD);
    rd_count_d = rd_count_q + 16'(rd_cmd && hit);
    wr_count_d = wr_count_q + 16'(wr_cmd && hit);
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q      <= '0;
      hit_q      <= '0;
      err_wr_q   <= 1'b0;
      rd_count_q <= 16'h0;
      wr_count_q <= 16'h0;
    end else begin
      vld_q      <= vld_d;
      hit_q      <= hit_d;
      err_wr_q   <= err_wr_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // NOTE: data stages and the memory array are deliberately left unreset; outputs are gated by
  // the reset valid bits, and memory contents must survive a reset.
  always_ff @(posedge clock) begin
    dat_q <= dat_d;
  end

  always_ff @(posedge clock) begin
    if (wr_cmd && hit) begin
      mem_q[idx] <= bus.data;
    end
  end

  assign rd_valid      = vld_q[RD_LATENCY-1] & hit_q[RD_LATENCY-1];
  assign bus.rd_valid  = rd_valid;
  assign bus.data_read = rd_valid ? dat_q[RD_LATENCY-1] : 32'h0;
  assign bus.err       = err_wr_q | (vld_q[RD_LATENCY-1] & ~hit_q[RD_LATENCY-1]);
  assign bus.rd_count  = rd_count_q;
  assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Scoreboard bench for bus_slave_mem: the driver queues expected rd_valid/err events tagged with
// the cycle they must appear in; an independent monitor pops and compares them every cycle.
module tb_bus_slave_mem;

  localparam int         L        = 2;
  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef struct {
    int          cyc;
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  bus_slave_mem_if bus ();

  bus_slave_mem #(
    .ADDR_BITS (4),
    .BASE_ADR  (16'h0000),
    .RD_LATENCY(L)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // cyc = number of rising edges so far; stable while sampled on the falling edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  exp_t        sb[$];
  logic [31:0] model [16];
  logic [15:0] rd_exp   = 16'h0;
  logic [15:0] wr_exp   = 16'h0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Insert in cycle order; two err events landing in the same cycle collapse into one pulse.
  task automatic push_exp(input int c, input bit is_err, input logic [31:0] d);
    exp_t e;
    int   pos;
    foreach (sb[k]) if (is_err && sb[k].is_err && sb[k].cyc == c) return;
    e.cyc = c; e.is_err = is_err; e.data = d;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].cyc > c) pos--;
    sb.insert(pos, e);
  endtask

  // Drive one command at the falling edge; it is sampled at rising edge s = cyc+1. A read is
  // registered at s and shifts through L stages, so it is high in the cycle after edge s+L-1;
  // a rejected write/reserved op shows err in the cycle after edge s.
  task automatic issue(input logic [1:0] op, input logic [15:0] adr, input logic [31:0] d);
    int s;
    bit in_win;
    s      = cyc + 1;
    in_win = (adr < 16'd16);
    bus.op = op; bus.adr = adr; bus.data = d;
    case (op)
      OP_READ: begin
        if (in_win) begin
          push_exp(s + L - 1, 1'b0, model[adr[3:0]]);
          rd_exp++;
        end else begin
          push_exp(s + L - 1, 1'b1, 32'h0);
        end
      end
      OP_WRITE: begin
        if (in_win) begin
          model[adr[3:0]] = d;
          wr_exp++;
        end else begin
          push_exp(s, 1'b1, 32'h0);
        end
      end
      OP_RSVD: push_exp(s, 1'b1, 32'h0);
      default: ;
    endcase
    @(negedge clock);
    bus.op = OP_IDLE;
  endtask

  task automatic idle(input int n);
    bus.op = OP_IDLE;
    repeat (n) @(negedge clock);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rd_count"}, 32'(bus.rd_count), 32'(rd_exp));
    check({tag, "_wr_count"}, 32'(bus.wr_count), 32'(wr_exp));
  endtask

  // Monitor: decoupled from the driver, consumes scoreboard entries as the DUT presents them.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("event_seen_cyc", 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if (bus.rd_valid || bus.err) begin
        if (sb.size() == 0) begin
          check("event_expected", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("evt_cyc", 32'(cyc), 32'(e.cyc));
          check("evt_err", 32'(bus.err), 32'(e.is_err));
          check("evt_rd_valid", 32'(bus.rd_valid), 32'(!e.is_err));
          if (!e.is_err) check("rd_data", bus.data_read, e.data);
        end
      end else begin
        check("idle_data_zero", bus.data_read, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (model[k]) model[k] = 'x;
    bus.op = OP_IDLE; bus.adr = 16'h0; bus.data = 32'h0;
    repeat (3) @(negedge clock);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_data_read", bus.data_read, 32'h0);
    check_counts("rst");
    reset_n = 1'b1;

    // Write then read the same word on the very next edge.
    issue(OP_WRITE, 16'h0003, 32'hCAFE_0001);
    issue(OP_READ, 16'h0003, 32'h0);
    idle(L + 1);
    check("t1_wr_count", 32'(bus.wr_count), 32'd1);
    check("t1_rd_count", 32'(bus.rd_count), 32'd1);

    // Fill every word with adr*3, then stream 16 back-to-back reads (0,3,...,45).
    for (int i = 0; i < 16; i++) issue(OP_WRITE, 16'(i), 32'(i * 3));
    for (int i = 0; i < 16; i++) issue(OP_READ, 16'(i), 32'h0);
    idle(L + 1);
    check_counts("fill");

    // Rejected commands: read just past the window, write miss, reserved op, top of address space.
    issue(OP_READ, 16'h0010, 32'h0);
    idle(L + 1);
    check_counts("rd_miss");
    issue(OP_WRITE, 16'h0010, 32'hDEAD_BEEF);
    issue(OP_RSVD, 16'h0000, 32'h1234_5678);
    issue(OP_WRITE, 16'hFFFF, 32'h5555_AAAA);
    idle(2);
    check_counts("wr_miss");
    issue(OP_READ, 16'h0000, 32'h0);
    issue(OP_READ, 16'h000F, 32'h0);
    idle(L + 1);

    // Read-miss err and write-miss err land in the same cycle: one merged pulse.
    issue(OP_READ, 16'h0020, 32'h0);
    issue(OP_WRITE, 16'h0020, 32'h1);
    idle(L + 2);
    check_counts("merge");

    // Overwrite then immediate read-back.
    issue(OP_WRITE, 16'h0007, 32'hA5A5_5A5A);
    issue(OP_READ, 16'h0007, 32'h0);
    idle(L + 1);

    // Reset with a read hit in flight, then with a read miss in flight: both are discarded.
    issue(OP_READ, 16'h0005, 32'h0);
    sb.delete(); rd_exp = 16'h0; wr_exp = 16'h0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(L + 2);
    check_counts("rst_hit");
    issue(OP_READ, 16'h0100, 32'h0);
    sb.delete();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(L + 2);
    check_counts("rst_miss");
    issue(OP_READ, 16'h0005, 32'h0);
    issue(OP_READ, 16'h0006, 32'h0);
    idle(L + 1);
    check_counts("post_rst");

    // 65537 write hits: wr_count passes 16'hFFFF and wraps to 16'h0001.
    for (int i = 0; i < 65537; i++) begin
      issue(OP_WRITE, 16'(i % 16), 32'(i));
      if (i == 65534) check("wrap_ffff", 32'(bus.wr_count), 32'h0000_FFFF);
    end
    check("wrap_wr_count", 32'(bus.wr_count), 32'h0000_0001);
    check_counts("wrap");
    issue(OP_READ, 16'h0000, 32'h0);
    issue(OP_READ, 16'h000F, 32'h0);
    idle(L + 2);
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_slave_mem.md
BUS_SLAVE_MEM -- requirements
Module: bus_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 4, word-address width of internal memory (depth 2**ADDR_BITS x 32).
REQ-002 SHALL have parameter BASE_ADR, default 16'h0000, first bus address decoded by this slave.
REQ-003 SHALL have parameter RD_LATENCY, default 2, legal 1..4, cycles from read command sample to rd_valid.
REQ-004 SHALL have one clock and asynchronous active-low reset; ports follow.
REQ-005 clock  in  1  sole clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 op  in  2  bus command: 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 reserved.
REQ-008 adr  in  16  bus word address, qualified by op.
REQ-009 data  in  32  write data, qualified by op==write.
REQ-010 data_read  out  32  read return data, valid only with rd_valid.
REQ-011 rd_valid  out  1  one-cycle pulse per successful read.
REQ-012 err  out  1  one-cycle pulse per rejected command.
REQ-013 rd_count  out  16  count of accepted reads, wraps 16'hFFFF->0.
REQ-014 wr_count  out  16  count of accepted writes, wraps 16'hFFFF->0.

Function
REQ-015 SHALL sample op/adr/data every rising edge; one command per cycle, no stalls, no backpressure.
REQ-016 SHALL decode hit when BASE_ADR <= adr < BASE_ADR + 2**ADDR_BITS (16-bit unsigned compare, no wrap past 16'hFFFF); mem index = adr - BASE_ADR truncated to ADDR_BITS.
REQ-017 Write hit: SHALL update memory at the sampling edge; wr_count increments same edge.
REQ-018 Read hit: SHALL enter a RD_LATENCY-deep pipeline; data_read/rd_valid=1 exactly RD_LATENCY cycles after sample edge; rd_count increments at sample edge.
REQ-019 Reads SHALL be fully pipelined: back-to-back reads give back-to-back rd_valid pulses in issue order.
REQ-020 Read SHALL return memory contents including every write sampled on an earlier edge (write at N, read at N+1 same address returns new data).
REQ-021 data_read SHALL be 32'h0 whenever rd_valid=0.
REQ-022 Read miss: SHALL pulse err (rd_valid stays 0) in the slot where rd_valid would have asserted (RD_LATENCY cycles after sample); rd_count unchanged.
REQ-023 Write miss or op==2'b11: SHALL pulse err one cycle after sample edge; memory and counters unchanged.
REQ-024 If a write-miss/reserved err and a read-miss err fall in the same cycle, err SHALL be 1 for that single cycle (OR).
REQ-025 Idle op SHALL have no effect except advancing the read pipeline.
REQ-026 Pipeline SHALL be tracked as valid/hit bits plus data per stage; no other state machine.

Reset
REQ-027 On reset_n low, asynchronously: data_read=0, rd_valid=0, err=0, rd_count=0, wr_count=0, all pipeline valid bits 0.
REQ-028 Memory contents SHALL NOT be reset; content after reset is retained from before reset (undefined at power-up).
REQ-029 Reads in flight when reset asserts SHALL be discarded: no rd_valid or err for them after release.
REQ-030 Commands SHALL be sampled from the first rising edge with reset_n high.

Verification
REQ-031 Write 32'hCAFE_0001 @ adr 16'h0003, then read 16'h0003 next cycle (RD_LATENCY=2) -> rd_valid pulse 2 cycles after read sample, data_read=32'hCAFE_0001, wr_count=1, rd_count=1.
REQ-032 Fill adr 0..15 with value adr*3, then 16 back-to-back reads -> 16 consecutive rd_valid cycles returning 0,3,...,45 in order.
REQ-033 Read adr 16'h0010 (BASE 0, ADDR_BITS 4) -> err pulse 2 cycles later, no rd_valid, rd_count unchanged; write 16'h0010 and op 2'b11 -> err next cycle, memory unchanged.
REQ-034 Issue 2 reads, assert reset_n low for 1 cycle between -> no rd_valid/err after release, counters 0; re-read returns pre-reset data.
REQ-035 Perform 65537 writes -> wr_count wraps to 16'h0001.
